// File: rtl/wave_dac_if.sv
// Waveform-to-DAC output stage: gain/offset pipeline with saturation, a priming
// FIFO, and a rate-divided drain that updates the DAC code.
module wave_dac_if #(
    parameter int WAVE_WIDTH = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wave_valid,
    input  logic [WAVE_WIDTH-1:0] wave_in,
    input  logic [15:0]           gain,
    input  logic [WAVE_WIDTH-1:0] offset,
    input  logic                  enable,
    input  logic [DIV_WIDTH-1:0]  rate_div,
    input  logic [FIFO_DEPTH:0]   prime_level,
    input  logic [WAVE_WIDTH-1:0] idle_value,
    input  logic                  clear_flags,
    output logic [WAVE_WIDTH-1:0] dac_data,
    output logic                  dac_strobe,
    output logic [FIFO_DEPTH:0]   fifo_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PROD_WIDTH = WAVE_WIDTH + 16;
    localparam int SUM_WIDTH  = PROD_WIDTH + 1;
    localparam int ENTRIES    = 1 << FIFO_DEPTH;

    localparam logic [FIFO_DEPTH:0] FULL_LEVEL = (FIFO_DEPTH + 1)'(ENTRIES);
    localparam logic signed [SUM_WIDTH-1:0] SAT_MAX =
        {{(SUM_WIDTH - WAVE_WIDTH + 1){1'b0}}, {(WAVE_WIDTH - 1){1'b1}}};
    localparam logic signed [SUM_WIDTH-1:0] SAT_MIN =
        {{(SUM_WIDTH - WAVE_WIDTH + 1){1'b1}}, {(WAVE_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_STREAM
    } state_t;

    state_t state;
    state_t state_next;

    // Sample pipeline
    logic                          s1_valid;
    logic signed [PROD_WIDTH-1:0]  s1_product;
    logic                          s2_valid;
    logic        [WAVE_WIDTH-1:0]  s2_data;
    logic signed [SUM_WIDTH-1:0]   sum;
    logic        [WAVE_WIDTH-1:0]  sat_value;

    // FIFO
    logic [WAVE_WIDTH-1:0] mem [ENTRIES];
    logic [FIFO_DEPTH-1:0] wr_ptr;
    logic [FIFO_DEPTH-1:0] rd_ptr;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  flush;
    logic                  push_req;
    logic                  push;
    logic                  pop;

    // Rate divider and flag events
    logic [DIV_WIDTH-1:0]  cnt;
    logic                  tick;
    logic                  overflow_set;
    logic                  underflow_set;

    always_comb begin
        sum = SUM_WIDTH'(s1_product >>> 8) + SUM_WIDTH'($signed(offset));
        if (sum > SAT_MAX) begin
            sat_value = {1'b0, {(WAVE_WIDTH - 1){1'b1}}};
        end else if (sum < SAT_MIN) begin
            sat_value = {1'b1, {(WAVE_WIDTH - 1){1'b0}}};
        end else begin
            sat_value = sum[WAVE_WIDTH-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            s1_valid <= enable & wave_valid;
            s2_valid <= enable & s1_valid;
        end
    end

    // NOTE: datapath registers and FIFO storage carry no reset; the valid bits
    // and pointers define what is meaningful, and skipping the reset keeps the
    // storage mappable to plain RAM.
    always_ff @(posedge clk) begin
        s1_product <= PROD_WIDTH'($signed(wave_in)) * PROD_WIDTH'($signed(gain));
        s2_data    <= sat_value;
        if (push) begin
            mem[wr_ptr] <= s2_data;
        end
    end

    assign fifo_full  = (fifo_level == FULL_LEVEL);
    assign fifo_empty = (fifo_level == '0);
    assign flush      = !enable || (state == ST_IDLE);

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_next    = state;
        tick          = 1'b0;
        underflow_set = 1'b0;
        if (!enable) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_next = ST_PRIME;
                end
                ST_PRIME: begin
                    if (fifo_level >= prime_level) begin
                        state_next = ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (cnt == '0) begin
                        tick = 1'b1;
                        if (fifo_empty) begin
                            underflow_set = 1'b1;
                            state_next    = ST_PRIME;
                        end
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    // A full FIFO still accepts a write when the same edge pops the head.
    assign pop          = tick && !fifo_empty;
    assign push_req     = s2_valid && !flush;
    assign push         = push_req && (!fifo_full || pop);
    assign overflow_set = push_req && fifo_full && !pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Counter is held at rate_div outside STREAM so streaming starts a full period.
    always_ff @(posedge clk) begin
        if (reset || state != ST_STREAM || !enable || tick) begin
            cnt <= rate_div;
        end else begin
            cnt <= cnt - DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_DEPTH'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_DEPTH'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (FIFO_DEPTH + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (FIFO_DEPTH + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_data   <= '0;
            dac_strobe <= 1'b0;
        end else begin
            dac_strobe <= pop;
            if (flush) begin
                dac_data <= idle_value;
            end else if (pop) begin
                dac_data <= mem[rd_ptr];
            end
        end
    end

    // A set event outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= overflow_set  || (overflow  && !clear_flags);
            underflow <= underflow_set || (underflow && !clear_flags);
        end
    end

endmodule
